// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_share_arbiter.
// The arbiter uses the slave modport; requesters, ALU and benches use master.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SEL_W-1:0] req0_sel;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_y;
  logic             rsp0_cout;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SEL_W-1:0] req1_sel;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_y;
  logic             rsp1_cout;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;

  logic             busy;
  logic             owner;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
    input  alu_y, alu_cout,
    output req0_ready, rsp0_valid, rsp0_y, rsp0_cout,
    output req1_ready, rsp1_valid, rsp1_y, rsp1_cout,
    output alu_a, alu_b, alu_sel, busy, owner
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
    output alu_y, alu_cout,
    input  req0_ready, rsp0_valid, rsp0_y, rsp0_cout,
    input  req1_ready, rsp1_valid, rsp1_y, rsp1_cout,
    input  alu_a, alu_b, alu_sel, busy, owner
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept, hold operands ALU_LAT cycles, capture, return on the owner's channel.
module alu_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic [WIDTH-1:0] r_rsp0_y;
  logic [WIDTH-1:0] r_rsp1_y;
  logic             r_rsp0_cout;
  logic             r_rsp1_cout;

  logic w_idle;
  logic w_ready0;
  logic w_ready1;
  logic w_rsp_ready;

  // On a tie the requester that was not granted last wins.
  assign w_idle      = (r_state == S_IDLE);
  assign w_ready0    = w_idle & bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_ready1    = w_idle & bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= 3'd0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp0_y     <= '0;
      r_rsp1_y     <= '0;
      r_rsp0_cout  <= 1'b0;
      r_rsp1_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ready0 | w_ready1) begin
            r_alu_a      <= w_ready1 ? bus.req1_a   : bus.req0_a;
            r_alu_b      <= w_ready1 ? bus.req1_b   : bus.req0_b;
            r_alu_sel    <= w_ready1 ? bus.req1_sel : bus.req0_sel;
            r_owner      <= w_ready1;
            r_last_grant <= w_ready1;
            r_cnt        <= 3'd0;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST_CNT) begin
            if (r_owner) begin
              r_rsp1_y    <= bus.alu_y;
              r_rsp1_cout <= bus.alu_cout;
            end else begin
              r_rsp0_y    <= bus.alu_y;
              r_rsp0_cout <= bus.alu_cout;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = (r_state == S_RESP) & ~r_owner;
  assign bus.rsp1_valid = (r_state == S_RESP) & r_owner;
  assign bus.rsp0_y     = r_rsp0_y;
  assign bus.rsp1_y     = r_rsp1_y;
  assign bus.rsp0_cout  = r_rsp0_cout;
  assign bus.rsp1_cout  = r_rsp1_cout;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.busy       = ~w_idle;
  assign bus.owner      = r_owner;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 8-bit ALU (logic and arithmetic segments) between two independent requesters. Each requester issues operand/select requests over a valid/ready channel. The block registers the operands into the ALU, waits a fixed settle time, captures the result and carry, and returns them on a per-requester response channel. It sits between requesting datapath masters and the gate-level ALU.

Parameters:
WIDTH, 8, operand and result width in bits.
SEL_W, 3, ALU select width; passed through opaque and never decoded here.
ALU_LAT, 1, cycles the ALU inputs are held before capture; legal range 1..4.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  arbiter accepts requester 0's operation.
req0_a, req0_b  input  WIDTH each  requester 0 operands.
req0_sel  input  SEL_W  requester 0 ALU select.
rsp0_valid  output  1  result for requester 0 available.
rsp0_ready  input  1  requester 0 takes the result.
rsp0_y  output  WIDTH  result to requester 0.
rsp0_cout  output  1  carry/borrow to requester 0.
req1_*, rsp1_*: identical set for requester 1.
alu_a, alu_b  output  WIDTH each  shared ALU operands.
alu_sel  output  SEL_W  shared ALU select.
alu_y  input  WIDTH  ALU result.
alu_cout  input  1  ALU carry out.
busy  output  1  high in any state other than IDLE.
owner  output  1  index of the requester currently served (or last served).

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1 (requester 0 wins the first tie), alu_a/alu_b/alu_sel=0, rsp*_y=0, rsp*_cout=0, rsp*_valid=0, busy=0, owner=0, settle counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: reqN_ready is combinational:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1; the other gets ready=0.
  - At most one ready is high in any cycle. ready=0 in EXEC and RESP.
- Accept on valid&ready at edge t:
  - Latch a/b/sel into the alu_* registers; owner=N, last_grant=N, counter=0; go to EXEC.
- EXEC:
  - alu_* held stable; counter increments each cycle.
  - On the ALU_LAT-th EXEC cycle, capture alu_y/alu_cout into the owner's rsp_y/rsp_cout; go to RESP.
- RESP:
  - rsp<owner>_valid=1 starting cycle t+ALU_LAT+1.
  - Held, with y/cout stable, until rsp<owner>_ready=1. At that edge valid drops and the state returns to IDLE.
  - If ready is already high when valid rises, completion takes one cycle.
  - The non-owner rsp_valid stays 0.
- Throughput: at most one operation per ALU_LAT+2 cycles. No new accept in the same cycle as a response handshake.
- alu_* hold their last values in IDLE and RESP; they are never driven by unaccepted requests.
- rsp_y/rsp_cout of each requester keep the last captured value after the handshake.
- Requesters must hold valid and operands until accepted. Dropping valid before acceptance withdraws the request with no side effect.
- Reset mid-EXEC or mid-RESP: the transaction is discarded, no response is produced, and all reset values are restored immediately (asynchronously).
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1.
- busy=1 exactly in EXEC and RESP.

Test Plan:
1. Reset, then req0 only, a=0xF0, b=0x3C, sel=AND encoding, ALU_LAT=1, rsp0_ready=1 -> req0_ready=1 in IDLE; rsp0_valid rises 2 cycles after accept with rsp0_y=0x30; busy=1 for 2 cycles; rsp1_valid never rises.
2. Both valid in the first cycle after reset: req0 ADD 0x7F+0x01, req1 XOR 0xAA^0xFF -> req0 served first (y=0x80, cout=0), then req1 (y=0x55); owner=0 then 1.
3. Both valid continuously for 6 operations -> grant order 0,1,0,1,0,1; never two ready signals high in one cycle.
4. Back-pressure: rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_valid, rsp1_y and alu_* remain stable; req0_ready stays 0 until the handshake completes.
5. ALU_LAT=3: accept at cycle t -> alu_a/b stable during t+1..t+3; result captured from the ALU value at t+3; rsp_valid at t+4.
6. Assert rst during EXEC of a req1 operation -> all outputs return to their reset values immediately; no rsp1_valid appears; the next tie is granted to req0.
